// File: rtl/type_definitions_pkg.sv
// Shared types for the RV32I instruction stream generator: instruction format structs,
// opcode/funct constants, instruction class enum, FSM state enum and LFSR helpers.
package type_definitions_pkg;

   typedef enum logic [2:0] {
      ClsR  = 3'd0,
      ClsI  = 3'd1,
      ClsS  = 3'd2,
      ClsSb = 3'd3,
      ClsU  = 3'd4,
      ClsUj = 3'd5
   } instr_class_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StGen  = 2'd1,
      StDone = 2'd2
   } gen_state_e;

   localparam logic [6:0] OpcR  = 7'b0110011;
   localparam logic [6:0] OpcI  = 7'b0010011;
   localparam logic [6:0] OpcS  = 7'b0100011;
   localparam logic [6:0] OpcSb = 7'b1100011;
   localparam logic [6:0] OpcU  = 7'b0110111;
   localparam logic [6:0] OpcUj = 7'b1101111;

   localparam logic [2:0] F3Add = 3'b000;
   localparam logic [2:0] F3Sll = 3'b001;
   localparam logic [2:0] F3Sr  = 3'b101;

   localparam logic [6:0] Funct7Base = 7'b0000000;
   localparam logic [6:0] Funct7Alt  = 7'b0100000;

   localparam logic [31:0] InstrNop = 32'h0000_0013;
   // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LfsrTaps = 32'h8020_0003;
   localparam logic [31:0] LaneSeedMul = 32'h9E37_79B9;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } r_type_t;

   typedef struct packed {
      logic [11:0] imm;
      logic [4:0]  rs1;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [6:0]  opcode;
   } i_type_t;

   typedef struct packed {
      logic [6:0] imm_hi;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] imm_lo;
      logic [6:0] opcode;
   } s_type_t;

   typedef struct packed {
      logic       imm_12;
      logic [5:0] imm_10_5;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [3:0] imm_4_1;
      logic       imm_11;
      logic [6:0] opcode;
   } sb_type_t;

   typedef struct packed {
      logic [19:0] imm_31_12;
      logic [4:0]  rd;
      logic [6:0]  opcode;
   } u_type_t;

   typedef struct packed {
      logic       imm_20;
      logic [9:0] imm_10_1;
      logic       imm_11;
      logic [7:0] imm_19_12;
      logic [4:0] rd;
      logic [6:0] opcode;
   } uj_type_t;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      logic [31:0] n;
      n = {1'b0, s[31:1]} ^ (s[0] ? LfsrTaps : 32'h0);
      return (n == 32'h0) ? 32'h1 : n;
   endfunction

   function automatic logic [31:0] lfsr_seed(input logic [31:0] seed, input int unsigned lane);
      logic [31:0] s;
      s = seed ^ (lane * LaneSeedMul);
      return (s == 32'h0) ? 32'h1 : s;
   endfunction

endpackage

// File: rtl/instr_lane_encoder.sv
// Combinational per-lane encoder: LFSR state + class mask -> one legal RV32I instruction.
// Optional RV32M R-type ops are enabled by defining INSTR_GEN_MEXT_EN.
module instr_lane_encoder
   import type_definitions_pkg::*;
(
   input  logic [31:0] lfsr_i,
   input  logic [5:0]  class_mask_i,
   output logic [31:0] instr_o
);

   logic [2:0]   base_idx;
   logic [2:0]   sel_idx;
   logic [3:0]   cand;
   instr_class_e cls;
   logic [4:0]   rd;
   logic [2:0]   f3_raw;
   logic [6:0]   br_off;
   logic [12:0]  sb_imm;
   logic [20:0]  uj_imm;
   r_type_t      r_enc;
   i_type_t      i_enc;
   s_type_t      s_enc;
   sb_type_t     sb_enc;
   u_type_t      u_enc;
   uj_type_t     uj_enc;

   // Class pick: start at lfsr[2:0] mod 6, walk upward with wrap to the first enabled class
   always_comb begin
      base_idx = (lfsr_i[2:0] > 3'd5) ? (lfsr_i[2:0] - 3'd6) : lfsr_i[2:0];
      sel_idx  = base_idx;
      cand     = 4'd0;
      for (int k = 5; k >= 0; k--) begin
         cand = {1'b0, base_idx} + 4'(k);
         if (cand > 4'd5) cand = cand - 4'd6;
         if (class_mask_i[cand[2:0]]) sel_idx = cand[2:0];
      end
   end

   assign cls    = instr_class_e'(sel_idx);
   assign rd     = (lfsr_i[11:7] == 5'd0) ? 5'd1 : lfsr_i[11:7];
   assign f3_raw = lfsr_i[6:4];
   // Branch/jump offset: 6 random bits shifted left, i.e. even and within -64..+62
   assign br_off = {lfsr_i[27:22], 1'b0};
   assign sb_imm = {{6{br_off[6]}}, br_off};
   assign uj_imm = {{14{br_off[6]}}, br_off};

   // Build every format from the LFSR bits
   always_comb begin
      r_enc.opcode = OpcR;
      r_enc.rd     = rd;
      r_enc.rs1    = lfsr_i[16:12];
      r_enc.rs2    = lfsr_i[21:17];
      r_enc.funct3 = f3_raw;
      r_enc.funct7 = (((f3_raw == F3Add) || (f3_raw == F3Sr)) && lfsr_i[3]) ? Funct7Alt
                                                                            : Funct7Base;
`ifdef INSTR_GEN_MEXT_EN
      if (lfsr_i[31]) begin
         r_enc.funct7 = 7'b0000001;
         r_enc.funct3 = lfsr_i[30:28];
      end
`endif

      i_enc.opcode = OpcI;
      i_enc.rd     = rd;
      i_enc.rs1    = lfsr_i[16:12];
      i_enc.funct3 = f3_raw;
      if (f3_raw == F3Sll) begin
         i_enc.imm = {Funct7Base, lfsr_i[24:20]};
      end else if (f3_raw == F3Sr) begin
         i_enc.imm = {(lfsr_i[3] ? Funct7Alt : Funct7Base), lfsr_i[24:20]};
      end else begin
         i_enc.imm = lfsr_i[31:20];
      end

      // Stores: SB/SH/SW only
      s_enc.opcode = OpcS;
      s_enc.rs1    = lfsr_i[16:12];
      s_enc.rs2    = lfsr_i[21:17];
      s_enc.funct3 = (f3_raw[1:0] == 2'b11) ? 3'b010 : {1'b0, f3_raw[1:0]};
      s_enc.imm_hi = lfsr_i[31:25];
      s_enc.imm_lo = lfsr_i[24:20];

      // Branches: 010/011 are reserved, fold them onto BEQ/BNE
      sb_enc.opcode   = OpcSb;
      sb_enc.rs1      = lfsr_i[16:12];
      sb_enc.rs2      = lfsr_i[21:17];
      sb_enc.funct3   = (f3_raw[2:1] == 2'b01) ? {2'b00, f3_raw[0]} : f3_raw;
      sb_enc.imm_12   = sb_imm[12];
      sb_enc.imm_11   = sb_imm[11];
      sb_enc.imm_10_5 = sb_imm[10:5];
      sb_enc.imm_4_1  = sb_imm[4:1];

      u_enc.opcode    = OpcU;
      u_enc.rd        = rd;
      u_enc.imm_31_12 = lfsr_i[31:12];

      uj_enc.opcode    = OpcUj;
      uj_enc.rd        = rd;
      uj_enc.imm_20    = uj_imm[20];
      uj_enc.imm_19_12 = uj_imm[19:12];
      uj_enc.imm_11    = uj_imm[11];
      uj_enc.imm_10_1  = uj_imm[10:1];
   end

   // Select the format of the chosen class
   always_comb begin
      unique case (cls)
         ClsR:    instr_o = r_enc;
         ClsI:    instr_o = i_enc;
         ClsS:    instr_o = s_enc;
         ClsSb:   instr_o = sb_enc;
         ClsU:    instr_o = u_enc;
         ClsUj:   instr_o = uj_enc;
         default: instr_o = InstrNop;
      endcase
   end

endmodule

// File: rtl/instr_stream_gen.sv
// Random RV32I instruction stream generator: emits count_i instructions, LANES per beat,
// under valid/ready flow control. Build macro INSTR_GEN_MEXT_EN adds RV32M R-type ops.
module instr_stream_gen
   import type_definitions_pkg::*;
#(
   parameter int unsigned LANES = 2,
   parameter int unsigned CNT_W = 16,
   parameter logic [31:0] SEED  = 32'hACE1_2468
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [CNT_W-1:0]      count_i,
   input  logic [5:0]            class_mask_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [LANES*32-1:0]   instr_o,
   output logic [LANES-1:0]      lane_valid_o,
   output logic                  busy_o,
   output logic                  done_o
);

   gen_state_e       state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [5:0]       mask_q, mask_d;
   logic [CNT_W-1:0] beat_cnt;
   logic             xfer;
   logic [LANES-1:0] lane_on;

   assign beat_cnt = (remaining_q >= CNT_W'(LANES)) ? CNT_W'(LANES) : remaining_q;
   assign xfer     = (state_q == StGen) && ready_i;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state: start only honoured in idle; last transfer moves to done
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_i) state_d = (count_i != '0) ? StGen : StDone;
         StGen:   if (xfer && (remaining_q == beat_cnt)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      valid_o = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      unique case (state_q)
         StGen: begin
            valid_o = 1'b1;
            busy_o  = 1'b1;
         end
         StDone:  done_o = 1'b1;
         default: ;
      endcase
   end

   // Capture request on start, count down on each transfer; empty mask means all classes
   always_comb begin
      remaining_d = remaining_q;
      mask_d      = mask_q;
      if ((state_q == StIdle) && start_i) begin
         remaining_d = count_i;
         mask_d      = (class_mask_i == 6'b0) ? 6'b111111 : class_mask_i;
      end else if (xfer) begin
         remaining_d = remaining_q - beat_cnt;
      end
   end

   // Request registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining_q <= '0;
         mask_q      <= '0;
      end else begin
         remaining_q <= remaining_d;
         mask_q      <= mask_d;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [31:0] lfsr_q, lfsr_d;
      logic [31:0] enc_instr;

      // Every lane steps on every transfer so lane streams stay independent of count
      assign lfsr_d = xfer ? lfsr_step(lfsr_q) : lfsr_q;

      // Lane LFSR
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) lfsr_q <= lfsr_seed(SEED, g);
         else        lfsr_q <= lfsr_d;
      end

      instr_lane_encoder u_enc (
         .lfsr_i       (lfsr_q),
         .class_mask_i (mask_q),
         .instr_o      (enc_instr)
      );

      assign lane_on[g] = (state_q == StGen) && (CNT_W'(g) < beat_cnt);
      assign instr_o[g*32 +: 32] = lane_on[g]         ? enc_instr :
                                   (state_q == StGen) ? InstrNop  : 32'h0;
   end

   assign lane_valid_o = lane_on;

endmodule

// File: tb/tb_instr_stream_gen.sv
// Self-checking bench for instr_stream_gen (LANES=2). Expected beats are queued from a
// bench-side LFSR/class model when a stream is requested and popped as beats transfer.
module tb_instr_stream_gen;

   localparam int unsigned LANES = 2;
   localparam int unsigned CNT_W = 16;
   localparam logic [31:0] SEED  = 32'hACE1_2468;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start_i = 1'b0;
   logic [CNT_W-1:0]     count_i = '0;
   logic [5:0]           class_mask_i = '0;
   logic                 ready_i = 1'b1;
   logic                 valid_o;
   logic [LANES*32-1:0]  instr_o;
   logic [LANES-1:0]     lane_valid_o;
   logic                 busy_o;
   logic                 done_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   instr_stream_gen #(
      .LANES (LANES),
      .CNT_W (CNT_W),
      .SEED  (SEED)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .count_i      (count_i),
      .class_mask_i (class_mask_i),
      .ready_i      (ready_i),
      .valid_o      (valid_o),
      .instr_o      (instr_o),
      .lane_valid_o (lane_valid_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   // Reference model state and scoreboard queues
   logic [31:0]         m_lfsr [LANES];
   logic [LANES-1:0]    exp_lv_q[$];
   logic [31:0]         exp_word_q[$];
   logic [LANES*32-1:0] got_instr_q[$];
   logic [LANES-1:0]    got_lv_q[$];
   logic [LANES*32-1:0] stall_q[$];
   logic [LANES*32-1:0] ref_q[$];
   logic [LANES*32-1:0] first_beat_ref;
   int                  done_at;
   int                  first_valid_at;
   int                  timed_out;

   function automatic logic [31:0] m_seed(input int lane);
      logic [31:0] s;
      s = SEED ^ (32'(lane) * 32'h9E37_79B9);
      return (s == 32'h0) ? 32'h1 : s;
   endfunction

   // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
   function automatic logic [31:0] m_step(input logic [31:0] s);
      logic [31:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 32'h8020_0003;
      return (n == 32'h0) ? 32'h1 : n;
   endfunction

   function automatic logic [6:0] m_opcode(input logic [31:0] s, input logic [5:0] mask);
      logic [6:0] ops [6];
      int idx;
      ops = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111};
      idx = int'(s[2:0]) % 6;
      for (int k = 0; k < 6; k++) begin
         if (mask[(idx + k) % 6]) return ops[(idx + k) % 6];
      end
      return 7'h00;
   endfunction

   task automatic push_expected(input int count, input logic [5:0] mask);
      int rem;
      int n;
      logic [5:0] m;
      logic [LANES-1:0] lv;
      rem = count;
      m = (mask == 6'b0) ? 6'b111111 : mask;
      while (rem > 0) begin
         n  = (rem > int'(LANES)) ? int'(LANES) : rem;
         lv = '0;
         for (int l = 0; l < int'(LANES); l++) begin
            if (l < n) begin
               lv[l] = 1'b1;
               exp_word_q.push_back({25'h0, m_opcode(m_lfsr[l], m)});
            end else begin
               exp_word_q.push_back(NOP);
            end
            m_lfsr[l] = m_step(m_lfsr[l]);
         end
         exp_lv_q.push_back(lv);
         rem -= n;
      end
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      start_i = 1'b0;
      ready_i = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int l = 0; l < int'(LANES); l++) m_lfsr[l] = m_seed(l);
      exp_lv_q.delete();
      exp_word_q.delete();
      @(negedge clk);
   endtask

   // Drive one stream (called just after a negedge); ready_i is held low for stall_len
   // cycles while beat number stall_beat is presented. Collects transferred beats.
   task automatic run_stream(input int count, input logic [5:0] mask, input int stall_beat,
                             input int stall_len);
      int c;
      int beats;
      int stalled;
      got_instr_q.delete();
      got_lv_q.delete();
      stall_q.delete();
      done_at        = -1;
      first_valid_at = -1;
      timed_out      = 0;
      start_i      = 1'b1;
      count_i      = CNT_W'(count);
      class_mask_i = mask;
      @(negedge clk);
      start_i = 1'b0;
      count_i = '0;
      c       = 1;
      beats   = 0;
      stalled = 0;
      forever begin
         ready_i = !((beats == stall_beat) && (stalled < stall_len));
         if (valid_o && (first_valid_at < 0)) first_valid_at = c;
         if (valid_o && !ready_i) begin
            stall_q.push_back(instr_o);
            stalled++;
         end
         if (valid_o && ready_i) begin
            got_instr_q.push_back(instr_o);
            got_lv_q.push_back(lane_valid_o);
            beats++;
         end
         if (done_o) begin
            done_at = c;
            break;
         end
         if (c >= 3000) begin
            timed_out = 1;
            break;
         end
         @(negedge clk);
         c++;
      end
      ready_i = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      total++; if (valid_o !== 1'b0) begin bad++;
         $display("FAIL reset_valid got=%b want=0", valid_o); end
      total++; if (lane_valid_o !== '0) begin bad++;
         $display("FAIL reset_lane_valid got=%b want=0", lane_valid_o); end
      total++; if (instr_o !== '0) begin bad++;
         $display("FAIL reset_instr got=%h want=0", instr_o); end
      total++; if (busy_o !== 1'b0) begin bad++;
         $display("FAIL reset_busy got=%b want=0", busy_o); end
      total++; if (done_o !== 1'b0) begin bad++;
         $display("FAIL reset_done got=%b want=0", done_o); end
   endtask

   task automatic test_basic();
      logic [LANES-1:0] elv;
      logic [31:0] ew;
      logic [31:0] gw;
      push_expected(5, 6'b0);
      run_stream(5, 6'b0, -1, 0);
      total++; if (timed_out != 0) begin bad++; $display("FAIL basic_timeout got=1 want=0"); end
      total++; if (first_valid_at != 1) begin bad++;
         $display("FAIL basic_latency got=%0d want=1", first_valid_at); end
      total++; if (got_lv_q.size() != 3) begin bad++;
         $display("FAIL basic_beats got=%0d want=3", got_lv_q.size()); end
      for (int b = 0; b < got_lv_q.size() && exp_lv_q.size() > 0; b++) begin
         elv = exp_lv_q.pop_front();
         total++; if (got_lv_q[b] !== elv) begin bad++;
            $display("FAIL basic_lane_valid beat=%0d got=%b want=%b", b, got_lv_q[b], elv); end
         for (int l = 0; l < int'(LANES); l++) begin
            ew = exp_word_q.pop_front();
            gw = got_instr_q[b][l*32 +: 32];
            total++;
            if (elv[l] ? (gw[6:0] !== ew[6:0]) : (gw !== ew)) begin bad++;
               $display("FAIL basic_word beat=%0d lane=%0d got=%h want=%h", b, l, gw, ew); end
         end
      end
      total++; if (done_at != 4) begin bad++;
         $display("FAIL basic_done_cycle got=%0d want=4", done_at); end
      total++; if ((valid_o !== 1'b0) || (busy_o !== 1'b0)) begin bad++;
         $display("FAIL basic_idle_after got=%b%b want=00", valid_o, busy_o); end
      if (got_instr_q.size() > 0) first_beat_ref = got_instr_q[0];
   endtask

   task automatic test_zero_count();
      run_stream(0, 6'b0, -1, 0);
      total++; if (first_valid_at != -1) begin bad++;
         $display("FAIL zero_valid got=%0d want=-1", first_valid_at); end
      total++; if (done_at != 1) begin bad++;
         $display("FAIL zero_done_cycle got=%0d want=1", done_at); end
   endtask

   task automatic test_stall();
      logic [LANES-1:0] elv;
      logic [31:0] ew;
      logic [31:0] gw;
      do_reset();
      run_stream(10, 6'b0, -1, 0);
      ref_q = got_instr_q;
      do_reset();
      push_expected(10, 6'b0);
      run_stream(10, 6'b0, 2, 4);
      total++; if (stall_q.size() != 4) begin bad++;
         $display("FAIL stall_cycles got=%0d want=4", stall_q.size()); end
      for (int i = 0; i < stall_q.size() && got_instr_q.size() > 2; i++) begin
         total++; if (stall_q[i] !== got_instr_q[2]) begin bad++;
            $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, stall_q[i], got_instr_q[2]);
         end
      end
      total++; if (got_instr_q.size() != ref_q.size()) begin bad++;
         $display("FAIL stall_len got=%0d want=%0d", got_instr_q.size(), ref_q.size()); end
      for (int b = 0; b < got_instr_q.size() && b < ref_q.size(); b++) begin
         total++; if (got_instr_q[b] !== ref_q[b]) begin bad++;
            $display("FAIL stall_seq beat=%0d got=%h want=%h", b, got_instr_q[b], ref_q[b]); end
      end
      for (int b = 0; b < got_lv_q.size() && exp_lv_q.size() > 0; b++) begin
         elv = exp_lv_q.pop_front();
         total++; if (got_lv_q[b] !== elv) begin bad++;
            $display("FAIL stall_lane_valid beat=%0d got=%b want=%b", b, got_lv_q[b], elv); end
         for (int l = 0; l < int'(LANES); l++) begin
            ew = exp_word_q.pop_front();
            gw = got_instr_q[b][l*32 +: 32];
            total++;
            if (elv[l] ? (gw[6:0] !== ew[6:0]) : (gw !== ew)) begin bad++;
               $display("FAIL stall_word beat=%0d lane=%0d got=%h want=%h", b, l, gw, ew); end
         end
      end
      total++; if (done_at != 10) begin bad++;
         $display("FAIL stall_done_cycle got=%0d want=10", done_at); end
   endtask

   task automatic test_sb_class();
      int n_instr;
      int opc_bad;
      int rng_bad;
      int f3_bad;
      logic [31:0] w;
      logic signed [12:0] off;
      do_reset();
      run_stream(1000, 6'b001000, -1, 0);
      n_instr = 0; opc_bad = 0; rng_bad = 0; f3_bad = 0;
      for (int b = 0; b < got_instr_q.size(); b++) begin
         for (int l = 0; l < int'(LANES); l++) begin
            if (got_lv_q[b][l]) begin
               w = got_instr_q[b][l*32 +: 32];
               n_instr++;
               if (w[6:0] !== 7'b1100011) opc_bad++;
               off = {w[31], w[7], w[30:25], w[11:8], 1'b0};
               if ((off < -64) || (off > 62)) rng_bad++;
               if ((w[14:12] == 3'b010) || (w[14:12] == 3'b011)) f3_bad++;
            end
         end
      end
      total++; if (timed_out != 0) begin bad++; $display("FAIL sb_timeout got=1 want=0"); end
      total++; if (n_instr != 1000) begin bad++;
         $display("FAIL sb_count got=%0d want=1000", n_instr); end
      total++; if (opc_bad != 0) begin bad++;
         $display("FAIL sb_opcode bad_count=%0d want=0", opc_bad); end
      total++; if (rng_bad != 0) begin bad++;
         $display("FAIL sb_offset_range bad_count=%0d want=0", rng_bad); end
      total++; if (f3_bad != 0) begin bad++;
         $display("FAIL sb_funct3 bad_count=%0d want=0", f3_bad); end
   endtask

   task automatic test_mext();
      int mext_seen;
      int rd0;
      int f7_bad;
      int opc_bad;
      logic [31:0] w;
      do_reset();
      run_stream(1000, 6'b000001, -1, 0);
      mext_seen = 0; rd0 = 0; f7_bad = 0; opc_bad = 0;
      for (int b = 0; b < got_instr_q.size(); b++) begin
         for (int l = 0; l < int'(LANES); l++) begin
            if (got_lv_q[b][l]) begin
               w = got_instr_q[b][l*32 +: 32];
               if (w[6:0] !== 7'b0110011) opc_bad++;
               if (w[11:7] == 5'd0) rd0++;
               if (w[31:25] == 7'b0000001) mext_seen++;
               else if (w[31:25] == 7'b0100000) begin
                  if ((w[14:12] != 3'b000) && (w[14:12] != 3'b101)) f7_bad++;
               end else if (w[31:25] != 7'b0000000) f7_bad++;
            end
         end
      end
      total++; if (opc_bad != 0) begin bad++;
         $display("FAIL mext_opcode bad_count=%0d want=0", opc_bad); end
      total++; if (rd0 != 0) begin bad++; $display("FAIL mext_rd_zero got=%0d want=0", rd0); end
      total++; if (f7_bad != 0) begin bad++;
         $display("FAIL mext_funct7 bad_count=%0d want=0", f7_bad); end
`ifdef INSTR_GEN_MEXT_EN
      total++; if (mext_seen == 0) begin bad++;
         $display("FAIL mext_present got=0 want=nonzero"); end
`else
      total++; if (mext_seen != 0) begin bad++;
         $display("FAIL mext_absent got=%0d want=0", mext_seen); end
`endif
   endtask

   task automatic test_reset_mid();
      int done_seen;
      do_reset();
      start_i      = 1'b1;
      count_i      = CNT_W'(10);
      class_mask_i = 6'b0;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      // beat 2 is now presented; pull reset mid-cycle
      #2 rst_n = 1'b0;
      #1;
      total++; if ((valid_o !== 1'b0) || (busy_o !== 1'b0)) begin bad++;
         $display("FAIL midrst_valid_busy got=%b%b want=00", valid_o, busy_o); end
      total++; if (lane_valid_o !== '0) begin bad++;
         $display("FAIL midrst_lane_valid got=%b want=0", lane_valid_o); end
      total++; if (instr_o !== '0) begin bad++;
         $display("FAIL midrst_instr got=%h want=0", instr_o); end
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 2) rst_n = 1'b1;
         if (done_o) done_seen++;
      end
      total++; if (done_seen != 0) begin bad++;
         $display("FAIL midrst_done got=%0d want=0", done_seen); end
      for (int l = 0; l < int'(LANES); l++) m_lfsr[l] = m_seed(l);
      run_stream(10, 6'b0, -1, 0);
      total++; if ((got_instr_q.size() == 0) || (got_instr_q[0] !== first_beat_ref)) begin
         bad++;
         $display("FAIL midrst_first_beat got=%h want=%h",
                  (got_instr_q.size() > 0) ? got_instr_q[0] : '0, first_beat_ref);
      end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_basic();
      test_zero_count();
      test_stall();
      test_sb_class();
      test_mext();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
